div_iter: RTL and testbench

//   Iterative radix-2 restoring divider serving the EX stage's DIV/DIVU path (div_start/opdata/signed/result/ready).

---
 rtl/div_iter_pkg.sv | 21 ++
 rtl/div_step.sv | 18 +
 rtl/div_iter.sv | 147 ++++++++++++++
 tb/tb_div_iter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state codes,
// handshake levels and the default operand width.
// Optional feature macro: DIV_SMALL_BYPASS_EN (see div_iter.sv).
package div_iter_pkg;

    localparam int DIV_DATA_W = 32;

    // Handshake levels on start_i / ready_o
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;
    localparam logic DIV_RESULT_NOT   = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: compare the shifted partial remainder against
// the divisor, subtract when it fits, and emit the resulting quotient bit.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   partial_rem_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] next_rem_o,
    output logic              q_bit_o
);

    // The partial remainder is always below 2*divisor, so when the subtract
    // succeeds the difference fits in DATA_W bits and wrap-around is exact.
    assign q_bit_o    = (partial_rem_i >= {1'b0, divisor_i});
    assign next_rem_o = q_bit_o ? (partial_rem_i[DATA_W-1:0] - divisor_i)
                                : partial_rem_i[DATA_W-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage DIV/DIVU path.
// Returns {remainder, quotient} 33 edges after a start is accepted
// (2 edges for a zero divisor). Signed operands are divided as magnitudes
// and fixed up when the result is loaded.
// Optional feature macro: DIV_SMALL_BYPASS_EN -- when |dividend| < |divisor|
// the result {dividend, 0} is produced one edge after start.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;     // partial remainder
    logic [DATA_W-1:0]   dvd_q;     // dividend bits shifting out, quotient bits shifting in
    logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic [DATA_W-1:0]   op1_mag;
    logic [DATA_W-1:0]   op2_mag;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quo_d;
    logic [DATA_W-1:0]   quo_fix_d;
    logic [DATA_W-1:0]   rem_fix_d;
    logic                abort;
    logic                cnt_last;

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    assign op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .partial_rem_i ({rem_q, dvd_q[DATA_W-1]}),
        .divisor_i     (dvs_q),
        .next_rem_o    (step_rem),
        .q_bit_o       (step_q)
    );

    assign quo_d     = {dvd_q[DATA_W-2:0], step_q};
    assign quo_fix_d = neg_quo_q ? -quo_d : quo_d;
    assign rem_fix_d = neg_rem_q ? -step_rem : step_rem;
    assign abort     = annul_i || (start_i == DIV_STOP);
    assign cnt_last  = (cnt_q == CNT_W'(DATA_W - 1));

    // FSM with iteration counter, work registers and registered outputs
    // NOTE: every register here uses <= so all branches see the pre-edge
    // values; mixing in = would make the step order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_q  <= DIV_RESULT_NOT;
                    result_q <= '0;
                    if ((start_i == DIV_START) && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DIV_BY_ZERO;
                        end
`ifdef DIV_SMALL_BYPASS_EN
                        else if (op1_mag < op2_mag) begin
                            state_q  <= DIV_END;
                            ready_q  <= DIV_RESULT_READY;
                            result_q <= {opdata1_i, {DATA_W{1'b0}}};
                        end
`endif
                        else begin
                            state_q   <= DIV_ON;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            dvd_q     <= op1_mag;
                            dvs_q     <= op2_mag;
                            neg_quo_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem_q <= signed_div_i && opdata1_i[DATA_W-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (abort) begin
                        state_q <= DIV_FREE;
                    end else begin
                        state_q  <= DIV_END;
                        ready_q  <= DIV_RESULT_READY;
                        result_q <= '0;
                    end
                end
                DIV_ON: begin
                    if (abort) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DIV_RESULT_NOT;
                        result_q <= '0;
                    end else begin
                        rem_q <= step_rem;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_last) begin
                            state_q  <= DIV_END;
                            ready_q  <= DIV_RESULT_READY;
                            result_q <= {rem_fix_d, quo_fix_d};
                        end
                    end
                end
                DIV_END: begin
                    if (abort) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DIV_RESULT_NOT;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q  <= DIV_FREE;
                    ready_q  <= DIV_RESULT_NOT;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized
// DIV/DIVU operations compared against plain-arithmetic expectations.
// Honours DIV_SMALL_BYPASS_EN for the expected latency.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int compared   = 0;
    int mismatched = 0;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected {remainder, quotient} from ordinary integer division.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;   // truncates toward zero
        r = sa % sb;   // takes the dividend's sign
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint mag(input logic sg, input logic [31:0] v);
        if (sg) return (longint'($signed(v)) < 0) ? -longint'($signed(v)) : longint'($signed(v));
        return longint'({32'd0, v});
    endfunction

    // Edges from the first edge with start high until ready_o is seen.
    function automatic int exp_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
`ifdef DIV_SMALL_BYPASS_EN
        if (mag(sg, a) < mag(sg, b)) return 1;
`endif
        return 33;
    endfunction

    // Full transaction: start held until ready, hold one extra cycle, release.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          edges;
        logic [63:0] exp_res;
        logic [63:0] held;
        exp_res = ref_div(sg, a, b);
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                // operands after acceptance must have no effect
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
        end while (!ready_o && edges < 100);
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat(sg, a, b)));
        check({tag, "_result"}, result_o, exp_res);
        held = result_o;
        @(posedge clk);
        #1;
        check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_result"}, result_o, held);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    // Count ready_o highs over a window with start low.
    task automatic watch_quiet(input int cycles, input string tag);
        int highs;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        check(tag, 64'(highs), 64'd0);
    endtask

    initial begin
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_div(1'b1, 32'd1234, 32'd0, "div_by_zero");
        run_div(1'b0, 32'hDEAD_BEEF, 32'd0, "divu_by_zero");
        run_div(1'b0, 32'd5, 32'd9, "divu_5_9");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max_max");

        // Annul at iteration 10, then annul held against start in IDLE
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        watch_quiet(5, "annul_idle_quiet");
        start_i = 1'b0;
        annul_i = 1'b0;
        watch_quiet(40, "annul_no_ready");
        run_div(1'b0, 32'd9, 32'd3, "divu_9_3_after_annul");

        // start dropped mid-divide aborts it
        @(negedge clk);
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        start_i = 1'b0;
        watch_quiet(40, "stop_no_ready");

        // Reset mid-ON, between edges
        @(negedge clk);
        opdata1_i = 32'd500;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(40, "rst_on_quiet");

        // Reset while a result is being presented clears it at once
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (33) @(posedge clk);
        #1;
        check("pre_rst_end_ready", 64'(ready_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "div_after_rst");

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    b = $urandom | 32'h0000_1000;
                    a = 32'($urandom_range(0, 4095));
                end
                default: b = -32'($urandom_range(1, 9));
            endcase
            run_div(sg, a, b, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
